// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one memory port between I-cache refill and d_mem.
// Define ARVI_ARB_RR_EN for round-robin tie-breaking; otherwise DM wins ties.
module mem_port_arbiter #(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN/8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_IC_DataReq,
  input  logic [XLEN-1:0] i_IC_Addr,
  output logic [XLEN-1:0] o_IC_Data,
  output logic            o_IC_MemReady,
  input  logic            i_DM_Wen,
  input  logic            i_DM_MemRead,
  input  logic [XLEN-1:0] i_DM_Addr,
  input  logic [XLEN-1:0] i_DM_Wd,
  input  logic [BE_W-1:0] i_DM_byte_en,
  output logic [XLEN-1:0] o_DM_ReadData,
  output logic            o_DM_data_ready,
  output logic            o_MEM_req,
  output logic            o_MEM_we,
  output logic [XLEN-1:0] o_MEM_addr,
  output logic [XLEN-1:0] o_MEM_wd,
  output logic [BE_W-1:0] o_MEM_be,
  input  logic [XLEN-1:0] i_MEM_rdata,
  input  logic            i_MEM_ack,
  output logic            o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  localparam logic OWN_IC = 1'b0;
  localparam logic OWN_DM = 1'b1;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]   wd_q, wd_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [XLEN-1:0]   ic_data_q, ic_data_d;
  logic [XLEN-1:0]   dm_data_q, dm_data_d;

  logic ic_req, dm_req, dm_win;
  assign ic_req = i_IC_DataReq;
  assign dm_req = i_DM_Wen | i_DM_MemRead;

`ifdef ARVI_ARB_RR_EN
  logic last_q, last_d;
  // On a tie the side that did not win last time gets the grant.
  assign dm_win = dm_req & (~ic_req | (last_q == OWN_IC));
`else
  assign dm_win = dm_req;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    be_d      = be_q;
    ic_data_d = ic_data_q;
    dm_data_d = dm_data_q;
`ifdef ARVI_ARB_RR_EN
    last_d    = last_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (ic_req | dm_req) begin
          state_d = S_BUSY;
          if (dm_win) begin
            owner_d = OWN_DM;
            we_d    = i_DM_Wen;
            addr_d  = i_DM_Addr;
            wd_d    = i_DM_Wd;
            be_d    = i_DM_byte_en;
          end else begin
            owner_d = OWN_IC;
            we_d    = 1'b0;
            addr_d  = i_IC_Addr;
            wd_d    = '0;
            be_d    = '1;
          end
`ifdef ARVI_ARB_RR_EN
          last_d = dm_win ? OWN_DM : OWN_IC;
`endif
        end
      end
      S_BUSY: begin
        if (i_MEM_ack) begin
          state_d = S_RESP;
          if (!we_q) begin
            if (owner_q == OWN_DM) dm_data_d = i_MEM_rdata;
            else                   ic_data_d = i_MEM_rdata;
          end
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IC;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wd_q      <= '0;
      be_q      <= '0;
      ic_data_q <= '0;
      dm_data_q <= '0;
`ifdef ARVI_ARB_RR_EN
      last_q    <= OWN_DM;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      be_q      <= be_d;
      ic_data_q <= ic_data_d;
      dm_data_q <= dm_data_d;
`ifdef ARVI_ARB_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign o_MEM_req       = (state_q == S_BUSY);
  assign o_MEM_we        = we_q;
  assign o_MEM_addr      = addr_q;
  assign o_MEM_wd        = wd_q;
  assign o_MEM_be        = be_q;
  assign o_IC_Data       = ic_data_q;
  assign o_DM_ReadData   = dm_data_q;
  assign o_IC_MemReady   = (state_q == S_RESP) && (owner_q == OWN_IC);
  assign o_DM_data_ready = (state_q == S_RESP) && (owner_q == OWN_DM);
  assign o_busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random requesters and a random-latency memory.
module tb_mem_port_arbiter;
  localparam int XLEN = 32;
  localparam int BE_W = 4;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_IC_DataReq = 1'b0;
  logic [XLEN-1:0] i_IC_Addr = '0;
  logic [XLEN-1:0] o_IC_Data;
  logic            o_IC_MemReady;
  logic            i_DM_Wen = 1'b0;
  logic            i_DM_MemRead = 1'b0;
  logic [XLEN-1:0] i_DM_Addr = '0;
  logic [XLEN-1:0] i_DM_Wd = '0;
  logic [BE_W-1:0] i_DM_byte_en = '0;
  logic [XLEN-1:0] o_DM_ReadData;
  logic            o_DM_data_ready;
  logic            o_MEM_req, o_MEM_we;
  logic [XLEN-1:0] o_MEM_addr, o_MEM_wd;
  logic [BE_W-1:0] o_MEM_be;
  logic [XLEN-1:0] i_MEM_rdata = '0;
  logic            i_MEM_ack = 1'b0;
  logic            o_busy;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.XLEN(XLEN), .BE_W(BE_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_IC_DataReq(i_IC_DataReq), .i_IC_Addr(i_IC_Addr),
    .o_IC_Data(o_IC_Data), .o_IC_MemReady(o_IC_MemReady),
    .i_DM_Wen(i_DM_Wen), .i_DM_MemRead(i_DM_MemRead), .i_DM_Addr(i_DM_Addr),
    .i_DM_Wd(i_DM_Wd), .i_DM_byte_en(i_DM_byte_en),
    .o_DM_ReadData(o_DM_ReadData), .o_DM_data_ready(o_DM_data_ready),
    .o_MEM_req(o_MEM_req), .o_MEM_we(o_MEM_we), .o_MEM_addr(o_MEM_addr),
    .o_MEM_wd(o_MEM_wd), .o_MEM_be(o_MEM_be),
    .i_MEM_rdata(i_MEM_rdata), .i_MEM_ack(i_MEM_ack), .o_busy(o_busy)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  typedef struct {logic we; logic [31:0] addr; logic [31:0] wd; logic [3:0] be;} mem_exp_t;
  typedef struct {logic side; logic [31:0] ic_data; logic [31:0] dm_data;} rsp_exp_t;
  mem_exp_t mq[$];
  rsp_exp_t rq[$];

  // Memory contents are a fixed hash of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hC0FFEE11;
  endfunction

  // Memory slave: random ack delay, random junk ack/data when no request is pending.
  bit ack_en    = 1'b1;
  int force_dly = -1;
  initial begin
    int  dly;
    bit  prev;
    dly  = 0;
    prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (ack_en) begin
        if (o_MEM_req) begin
          if (!prev) dly = (force_dly >= 0) ? force_dly : int'($urandom_range(0, 3));
          if (dly == 0) begin
            i_MEM_ack   = 1'b1;
            i_MEM_rdata = memf(o_MEM_addr);
          end else begin
            i_MEM_ack   = 1'b0;
            i_MEM_rdata = $urandom;
            dly--;
          end
        end else begin
          i_MEM_ack   = 1'($urandom_range(0, 1));
          i_MEM_rdata = $urandom;
        end
      end
      prev = o_MEM_req;
    end
  end

  // Memory-side monitor: fields match the predicted grant and stay stable while requesting.
  mem_exp_t mcur;
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (o_MEM_req) begin
        if (!prev) begin
          if (mq.size() == 0) chk("mem_unexpected_req", 1, 0);
          else mcur = mq.pop_front();
        end
        chk("mem_we", o_MEM_we, mcur.we);
        chk("mem_addr", o_MEM_addr, mcur.addr);
        chk("mem_wd", o_MEM_wd, mcur.wd);
        chk("mem_be", o_MEM_be, mcur.be);
        chk("mem_req_busy", o_busy, 1);
      end
      prev = o_MEM_req;
    end
  end

  // Response monitor: side and both data registers at every ready pulse.
  initial begin
    rsp_exp_t r;
    forever begin
      @(negedge i_clk);
      if (o_IC_MemReady || o_DM_data_ready) begin
        chk("ready_overlap", o_IC_MemReady & o_DM_data_ready, 0);
        chk("ready_req_low", o_MEM_req, 0);
        if (rq.size() == 0) chk("ready_unexpected", 1, 0);
        else begin
          r = rq.pop_front();
          chk("ready_side", o_DM_data_ready, r.side);
          chk("ic_data", o_IC_Data, r.ic_data);
          chk("dm_data", o_DM_ReadData, r.dm_data);
        end
      end
    end
  end

  // Reference model state
  bit          ic_p = 0, dm_p = 0;
  bit          model_last = 1'b1;   // 1 = DM
  logic [31:0] m_ic = '0, m_dm = '0;

  task automatic set_ic(input logic [31:0] a);
    i_IC_DataReq = 1'b1; i_IC_Addr = a; ic_p = 1;
  endtask

  task automatic set_dm(input bit we, input bit rd, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
    i_DM_Wen = we; i_DM_MemRead = rd; i_DM_Addr = a; i_DM_Wd = wd;
    i_DM_byte_en = be; dm_p = 1;
  endtask

  task automatic set_dm_rand();
    int k;
    k = $urandom_range(0, 2);
    set_dm(k != 1, k != 0, $urandom, $urandom, 4'($urandom));
  endtask

  // Predict the winner among pending requests, queue expectations, wait for its ready.
  task automatic arbitrate();
    bit       dmw, got;
    mem_exp_t m;
    rsp_exp_t r;
    if (!ic_p && !dm_p) return;
`ifdef ARVI_ARB_RR_EN
    dmw = dm_p && (!ic_p || !model_last);
`else
    dmw = dm_p;
`endif
    model_last = dmw;
    if (dmw) begin
      m.we = i_DM_Wen; m.addr = i_DM_Addr; m.wd = i_DM_Wd; m.be = i_DM_byte_en;
      if (!i_DM_Wen) m_dm = memf(i_DM_Addr);
    end else begin
      m.we = 1'b0; m.addr = i_IC_Addr; m.wd = '0; m.be = 4'hF;
      m_ic = memf(i_IC_Addr);
    end
    mq.push_back(m);
    r.side = dmw; r.ic_data = m_ic; r.dm_data = m_dm;
    rq.push_back(r);
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge i_clk);
      got = dmw ? o_DM_data_ready : o_IC_MemReady;
    end
    chk("ready_seen", got, 1);
    if (dmw) begin i_DM_Wen = 0; i_DM_MemRead = 0; dm_p = 0; end
    else begin i_IC_DataReq = 0; ic_p = 0; end
  endtask

  task automatic drain();
    while (ic_p || dm_p) arbitrate();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {o_IC_MemReady, o_DM_data_ready, o_MEM_req, o_MEM_we, o_busy}, 0);
    chk({tag, "_addr"}, o_MEM_addr, 0);
    chk({tag, "_wd"}, o_MEM_wd, 0);
    chk({tag, "_be"}, o_MEM_be, 0);
    chk({tag, "_icd"}, o_IC_Data, 0);
    chk({tag, "_dmd"}, o_DM_ReadData, 0);
  endtask

  initial begin
    bit seen;
    repeat (3) @(negedge i_clk);
    chk_all_zero("reset");
    i_rst = 1'b1;
    @(negedge i_clk);

    // Directed: IC read at 0x100 with immediate ack, DM byte write with 3-cycle delay.
    force_dly = 0;
    set_ic(32'h100); arbitrate();
    force_dly = 3;
    set_dm(1, 0, 32'h2001, 32'hAB00, 4'h2); arbitrate();
    force_dly = -1;
    // Write and read both asserted: behaves as a single write.
    set_dm(1, 1, 32'h40, 32'h1234_5678, 4'hF); arbitrate();

    // Ties held across three grants, the winner reissuing right after its ready.
    for (int i = 0; i < 3; i++) begin
      if (!ic_p) set_ic($urandom);
      if (!dm_p) set_dm_rand();
      arbitrate();
    end
    drain();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      if (!ic_p && $urandom_range(0, 1)) set_ic($urandom);
      if (!dm_p && $urandom_range(0, 1)) set_dm_rand();
      if (!ic_p && !dm_p) set_dm_rand();
      arbitrate();
    end
    drain();

    // Reset in the middle of a DM read: the late ack must not produce a ready.
    ack_en = 1'b0;
    i_MEM_ack = 1'b0;
    begin
      mem_exp_t m;
      m.we = 0; m.addr = 32'h80; m.wd = 32'h0; m.be = 4'h3;
      mq.push_back(m);
    end
    set_dm(0, 1, 32'h80, 32'h0, 4'h3);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge i_clk);
      seen = o_MEM_req;
    end
    chk("rst_busy_reached", seen, 1);
    i_rst = 1'b0; i_MEM_ack = 1'b1; i_MEM_rdata = 32'hDEAD_BEEF;
    i_DM_MemRead = 1'b0; dm_p = 0;
    @(negedge i_clk);
    chk_all_zero("midrst");
    i_rst = 1'b1;
    m_ic = '0; m_dm = '0; model_last = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("midrst_idle", o_busy, 0);
    i_MEM_ack = 1'b0;
    ack_en = 1'b1;
    set_dm(0, 1, 32'h84, 32'h0, 4'hF); arbitrate();
    set_ic(32'h200); set_dm(0, 1, 32'h88, 32'h0, 4'hF); arbitrate();
    drain();

    repeat (3) @(negedge i_clk);
    chk("rq_drained", rq.size(), 0);
    chk("mq_drained", mq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
